// File: rtl/reg_dest_scoreboard.sv
// reg_dest_scoreboard
// Destination-register scoreboard that sits between issue and the register file.
// Each register has a saturating pending-write counter. The issue stage uses the
// counters to detect read-after-write hazards and to stall when a counter is full.
// Writebacks decrement the counters and produce a registered one-hot write select.
// The hardwired-zero register is never tracked and never write-selected.
module reg_dest_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31,
   parameter int PEND_W   = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    issue_valid,
   input  logic [ADDR_W-1:0]       issue_addr,
   output logic                    issue_ready,
   input  logic                    wb_en,
   input  logic [ADDR_W-1:0]       wb_addr,
   input  logic [ADDR_W-1:0]       rd_addr_a,
   input  logic [ADDR_W-1:0]       rd_addr_b,
   output logic                    hazard_a,
   output logic                    hazard_b,
   output logic [(1<<ADDR_W)-1:0]  busy,
   output logic [(1<<ADDR_W)-1:0]  wr_sel,
   output logic                    err
);

   localparam int                NREG      = 1 << ADDR_W;
   localparam logic [PEND_W-1:0] CNT_MAX   = '1;
   localparam logic [PEND_W-1:0] CNT_ONE   = PEND_W'(1);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [PEND_W-1:0] cnt_q [NREG];
   logic [PEND_W-1:0] cnt_d [NREG];
   logic [NREG-1:0]   wr_sel_q;
   logic [NREG-1:0]   wr_sel_d;
   logic              err_q;
   logic              err_d;

   logic [NREG-1:0]   issue_dec;
   logic [NREG-1:0]   wb_dec;
   logic              issue_is_zero;
   logic              wb_is_zero;
   logic              issue_accept;
   logic              wb_underflow;

   // Address decoders; the zero register bit is masked so it can never be tracked or written
   always_comb begin
      issue_dec = '0;
      wb_dec    = '0;
      issue_dec[issue_addr] = 1'b1;
      wb_dec[wb_addr]       = 1'b1;
      issue_dec[ZERO_ADDR]  = 1'b0;
      wb_dec[ZERO_ADDR]     = 1'b0;
   end

   // Issue handshake and underflow detection, all judged on the pre-edge counts
   always_comb begin
      issue_is_zero = (issue_addr == ZERO_ADDR);
      wb_is_zero    = (wb_addr == ZERO_ADDR);
      issue_ready   = issue_is_zero | (cnt_q[issue_addr] != CNT_MAX);
      issue_accept  = issue_valid & issue_ready & ~issue_is_zero;
      wb_underflow  = wb_en & ~wb_is_zero & (cnt_q[wb_addr] == '0);
   end

   // Per-register counter update; a matched issue and decrement on one register cancel out
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         logic inc;
         logic dec;
         inc      = issue_accept & issue_dec[i];
         dec      = wb_en & wb_dec[i] & (cnt_q[i] != '0);
         cnt_d[i] = cnt_q[i];
         if (inc && !dec) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (dec && !inc) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   // Write select follows the writeback by one cycle; the error flag is sticky until reset
   always_comb begin
      wr_sel_d = wb_en ? wb_dec : '0;
      err_d    = err_q | wb_underflow;
   end

   // State registers with asynchronous reset that drops all pending counts at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         wr_sel_q <= '0;
         err_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         wr_sel_q <= wr_sel_d;
         err_q    <= err_d;
      end
   end

   // Status outputs derived directly from the current counts
   always_comb begin
      busy = '0;
      for (int i = 0; i < NREG; i++) begin
         busy[i] = (cnt_q[i] != '0);
      end
      busy[ZERO_ADDR] = 1'b0;
      hazard_a = busy[rd_addr_a];
      hazard_b = busy[rd_addr_b];
      wr_sel   = wr_sel_q;
      err      = err_q;
   end

endmodule
